axi_mem_arbiter: RTL
====================

# axi_mem_arbiter

Two-port arbiter that shares one `axi_controller` request interface (read/write/addr/store in, ready/load out, done handshake) between two independent requesters. Typical use: port 0 for the instruction fetch, port 1 for data accesses, both reaching the QSPI flash or any other AXI slave behind the controller. Round-robin grant, latched request fields, one transaction in flight at a time, and a sticky watchdog flag for stalled transactions.

## Interface
- `TIMEOUT_CYCLES`, default 1024: cycles a granted transaction may wait for `m_ready` before `timeout_flag` sets; 0 disables the watchdog.
- `clk`  in  1  system clock, all logic on the rising edge.
- `nrst`  in  1  asynchronous, active-low reset.
- `p0_read`, `p1_read`  in  1  read request, held by the requester until its ready pulse.
- `p0_write`, `p1_write`  in  2  write request code, passed to the controller unchanged; nonzero means write.
- `p0_addr`, `p1_addr`  in  32  byte address.
- `p0_store`, `p1_store`  in  32  write data.
- `p0_ready`, `p1_ready`  out  1  one-cycle completion pulse for that port.
- `p0_load`, `p1_load`  out  32  read data for that port.
- `m_read`  out  1  to controller `read`.
- `m_write`  out  2  to controller `write`.
- `m_addr`  out  32  to controller `addr`.
- `m_store`  out  32  to controller `store`.
- `m_done`  out  1  to controller `done`.
- `m_ready`  in  1  from controller `ready`.
- `m_load`  in  32  from controller `load`.
- `timeout_clear`  in  1  synchronous clear of `timeout_flag`.
- `timeout_flag`  out  1  sticky: a transaction exceeded `TIMEOUT_CYCLES`.

## Operation
- A port request is `pN_req = pN_read | (|pN_write)`. Read and write asserted together are forwarded as-is; the controller resolves them.
- State machine:
  - IDLE: no grant.
  - GRANT0: port 0 owns the controller.
  - GRANT1: port 1 owns the controller.
- IDLE → GRANTn on a clock edge where `pn_req` is 1.
  - If both ports request, grant the port opposite `last_grant`.
  - `last_grant` resets to 1, so port 0 wins the first tie.
- On entering GRANTn:
  - Capture `pn_read`, `pn_write`, `pn_addr`, `pn_store` into the `m_*` registers.
  - Set `last_grant = n`.
  - Clear the watchdog counter.
- The requester's inputs may change after the grant edge without affecting the transaction in flight.
- In GRANTn, on `m_ready = 1`:
  - `m_done = 1`, combinational, same cycle.
  - `pn_ready = 1`, combinational, same cycle.
  - `pn_load = m_load` and also register it.
  - Next state is IDLE and all `m_*` request registers clear to 0.
- At all other times `pN_load` holds the last registered value for that port, 0 after reset.
- `m_done` and `pN_ready` are 0 in IDLE, and in GRANTn while `m_ready = 0`.
- The non-granted port's ready is always 0. `m_ready` arriving in IDLE is ignored.
- Requester rule: drop or change the request in the cycle after its ready pulse. A request still asserted in IDLE is arbitrated again as a new transaction.
- Watchdog:
  - The counter increments every GRANTn cycle where `m_ready = 0`, and saturates.
  - `timeout_flag` sets when the count reaches `TIMEOUT_CYCLES` (nonzero parameter only).
  - It stays set until `timeout_clear` or reset; a set in the same cycle as `timeout_clear` wins.
  - The transaction is not aborted; the grant waits for `m_ready`.

## Timing
- Reset values: state IDLE, `last_grant` = 1, `m_read` = 0, `m_write` = 0, `m_addr` = 0, `m_store` = 0, counter 0, `timeout_flag` = 0, both `pN_load` = 0. The combinational outputs `m_done` and `pN_ready` are 0 during reset.
- Latency from request to `m_read`/`m_write` visible: 1 cycle (registered grant).
- Completion: `pN_ready` is in the same cycle as `m_ready`. Minimum port-to-port turnaround is 1 IDLE cycle between transactions.
- Back-to-back with both ports requesting: grants alternate 0, 1, 0, 1, …, with one IDLE cycle between each.
- Reset asserted mid-transaction: everything returns to reset values asynchronously. There is no pending ready afterwards, and requesters must re-issue.

## Test plan
- Port 0 reads 0x0080_0000 alone; controller returns 0xA5A5_1234 after 5 cycles → `m_read` = 1 one cycle after the request; `p0_ready` pulses once with `p0_load` = 0xA5A5_1234; `m_done` is coincident; `p1_ready` stays 0.
- Both ports request in the same cycle after reset → port 0 granted first, then port 1 after one IDLE cycle. Each port's `load` matches its own address's data.
- Port 1 writes `write` = 2'b11, address 0x10, store 0xDEAD_BEEF; the requester changes its addr and store the cycle after grant → `m_addr` stays 0x10 and `m_store` stays 0xDEAD_BEEF until `m_ready`.
- With `TIMEOUT_CYCLES` = 8, `m_ready` withheld for 20 cycles → `timeout_flag` rises after 8 waiting cycles. Completion still delivers `p0_ready`. The flag stays 1 until a `timeout_clear` pulse, then reads 0.
- `nrst` pulsed low while in GRANT1 → all outputs at reset values immediately. A later `m_ready` in IDLE produces no `pN_ready`. The next tie is granted to port 0.

Source files
------------

// File: rtl/axi_mem_arbiter.sv
// Round-robin arbiter sharing one axi_controller request port between two requesters.
// Request fields are latched at grant; a sticky watchdog flags transactions stalled on m_ready.
module axi_mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        p0_read,
  input  logic [1:0]  p0_write,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_store,
  output logic        p0_ready,
  output logic [31:0] p0_load,
  input  logic        p1_read,
  input  logic [1:0]  p1_write,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_store,
  output logic        p1_ready,
  output logic [31:0] p1_load,
  output logic        m_read,
  output logic [1:0]  m_write,
  output logic [31:0] m_addr,
  output logic [31:0] m_store,
  output logic        m_done,
  input  logic        m_ready,
  input  logic [31:0] m_load,
  input  logic        timeout_clear,
  output logic        timeout_flag
);

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_GRANT0 = 2'b01;
  localparam logic [1:0] ST_GRANT1 = 2'b10;

  localparam int            CW       = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic          WD_EN    = (TIMEOUT_CYCLES > 32'sd0);

  logic [1:0]    r_state;
  logic          r_last_grant;
  logic          r_m_read;
  logic [1:0]    r_m_write;
  logic [31:0]   r_m_addr;
  logic [31:0]   r_m_store;
  logic [CW-1:0] r_wd_cnt;
  logic          r_timeout_flag;
  logic [31:0]   r_p0_load;
  logic [31:0]   r_p1_load;

  logic [1:0] w_next_state;
  logic       w_p0_req;
  logic       w_p1_req;
  logic       w_granted;
  logic       w_start0;
  logic       w_start1;
  logic       w_p0_ready;
  logic       w_p1_ready;
  logic       w_wd_inc;
  logic       w_wd_hit;

  assign w_p0_req   = p0_read | (|p0_write);
  assign w_p1_req   = p1_read | (|p1_write);
  assign w_granted  = (r_state == ST_GRANT0) || (r_state == ST_GRANT1);
  assign w_start0   = (r_state == ST_IDLE) && (w_next_state == ST_GRANT0);
  assign w_start1   = (r_state == ST_IDLE) && (w_next_state == ST_GRANT1);
  assign w_p0_ready = m_ready && (r_state == ST_GRANT0);
  assign w_p1_ready = m_ready && (r_state == ST_GRANT1);
  assign w_wd_inc   = w_granted && !m_ready;
  assign w_wd_hit   = WD_EN && w_wd_inc && (r_wd_cnt == CNT_LAST);

  // Next-state logic: tie goes to the port opposite the last grant.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_p0_req && w_p1_req) begin
          w_next_state = r_last_grant ? ST_GRANT0 : ST_GRANT1;
        end else if (w_p0_req) begin
          w_next_state = ST_GRANT0;
        end else if (w_p1_req) begin
          w_next_state = ST_GRANT1;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_GRANT0, ST_GRANT1: begin
        if (m_ready) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = r_state;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State and round-robin pointer.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_next_state;
      if (w_start0) begin
        r_last_grant <= 1'b0;
      end else if (w_start1) begin
        r_last_grant <= 1'b1;
      end else begin
        r_last_grant <= r_last_grant;
      end
    end
  end

  // Request fields latched at grant so requesters may move on immediately.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_m_read  <= 1'b0;
      r_m_write <= 2'b00;
      r_m_addr  <= 32'h0000_0000;
      r_m_store <= 32'h0000_0000;
    end else if (w_start0) begin
      r_m_read  <= p0_read;
      r_m_write <= p0_write;
      r_m_addr  <= p0_addr;
      r_m_store <= p0_store;
    end else if (w_start1) begin
      r_m_read  <= p1_read;
      r_m_write <= p1_write;
      r_m_addr  <= p1_addr;
      r_m_store <= p1_store;
    end else if (w_granted && m_ready) begin
      r_m_read  <= 1'b0;
      r_m_write <= 2'b00;
      r_m_addr  <= 32'h0000_0000;
      r_m_store <= 32'h0000_0000;
    end else begin
      r_m_read  <= r_m_read;
      r_m_write <= r_m_write;
      r_m_addr  <= r_m_addr;
      r_m_store <= r_m_store;
    end
  end

  // Per-port read data hold registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_p0_load <= 32'h0000_0000;
      r_p1_load <= 32'h0000_0000;
    end else begin
      r_p0_load <= w_p0_ready ? m_load : r_p0_load;
      r_p1_load <= w_p1_ready ? m_load : r_p1_load;
    end
  end

  // Watchdog: flag fires once on the edge the saturating count reaches the limit.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wd_cnt       <= {CW{1'b0}};
      r_timeout_flag <= 1'b0;
    end else begin
      if (w_start0 || w_start1) begin
        r_wd_cnt <= {CW{1'b0}};
      end else if (w_wd_inc && (r_wd_cnt != CNT_MAX)) begin
        r_wd_cnt <= r_wd_cnt + CW'(1);
      end else begin
        r_wd_cnt <= r_wd_cnt;
      end
      if (w_wd_hit) begin
        r_timeout_flag <= 1'b1;
      end else if (timeout_clear) begin
        r_timeout_flag <= 1'b0;
      end else begin
        r_timeout_flag <= r_timeout_flag;
      end
    end
  end

  assign m_read       = r_m_read;
  assign m_write      = r_m_write;
  assign m_addr       = r_m_addr;
  assign m_store      = r_m_store;
  assign m_done       = w_p0_ready | w_p1_ready;
  assign p0_ready     = w_p0_ready;
  assign p1_ready     = w_p1_ready;
  assign p0_load      = w_p0_ready ? m_load : r_p0_load;
  assign p1_load      = w_p1_ready ? m_load : r_p1_load;
  assign timeout_flag = r_timeout_flag;

endmodule
